// File: rtl/div_disp_pkg.sv
// Shared types and constants for the divider result display.
// Seven-segment patterns are {g,f,e,d,c,b,a}, active-low.
package div_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // One double-dabble step: add 3 to nibbles >= 5, then shift b in.
    function automatic logic [7:0] dd_step(
        input logic [7:0] acc,
        input logic       b
    );
        logic [3:0] lo;
        logic [3:0] hi;
        lo = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
        hi = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
        return 8'({hi, lo, b});
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
// Codes above 9 and the blank request both show an unlit digit.
module seg7_decode
    import div_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/div_result_display.sv
// Captures divider quotient/remainder, converts to BCD serially and
// scans them onto a 4-digit multiplexed seven-segment display.
module div_result_display
    import div_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        q,
    input  logic [4:0]        r,
    input  logic              ok,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              busy,
    output logic              valid
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_ok_d;
    logic        w_rise;
    logic [4:0]  r_bq;
    logic [4:0]  r_br;
    logic [4:0]  r_pq;
    logic [4:0]  r_pr;
    logic        r_pend;
    logic [7:0]  r_accq;
    logic [7:0]  r_accr;
    logic [7:0]  r_dq;
    logic [7:0]  r_dr;
    logic [2:0]  r_shcnt;
    logic        r_valid;
    logic [CW-1:0] r_scan;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nx;
    logic        w_wrap;
    logic [3:0]  w_bcd;
    logic        w_blank;
    logic [6:0]  w_seg;

    assign w_rise = ok & ~r_ok_d;
    assign busy   = (r_state != ST_IDLE);
    assign valid  = r_valid;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_rise) w_state_nx = ST_LOAD;
            ST_LOAD:   w_state_nx = ST_SHIFT;
            ST_SHIFT:  if (r_shcnt == 3'd1) w_state_nx = ST_COMMIT;
            ST_COMMIT: w_state_nx = (w_rise || r_pend) ? ST_LOAD : ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ok_d  <= 1'b1;
            r_bq    <= '0;
            r_br    <= '0;
            r_pq    <= '0;
            r_pr    <= '0;
            r_pend  <= 1'b0;
            r_accq  <= '0;
            r_accr  <= '0;
            r_dq    <= '0;
            r_dr    <= '0;
            r_shcnt <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ok_d <= ok;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_bq <= q;
                        r_br <= r;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (r_state == ST_LOAD) begin
                        r_accq  <= '0;
                        r_accr  <= '0;
                        r_shcnt <= 3'd5;
                    end else begin
                        r_accq  <= dd_step(r_accq, r_bq[4]);
                        r_accr  <= dd_step(r_accr, r_br[4]);
                        r_bq    <= {r_bq[3:0], 1'b0};
                        r_br    <= {r_br[3:0], 1'b0};
                        r_shcnt <= r_shcnt - 3'd1;
                    end
                    if (w_rise) begin
                        r_pq   <= q;
                        r_pr   <= r;
                        r_pend <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_dq    <= r_accq;
                    r_dr    <= r_accr;
                    r_valid <= 1'b1;
                    r_pend  <= 1'b0;
                    // A rise coinciding with commit is newer than any pending pair.
                    if (w_rise) begin
                        r_bq <= q;
                        r_br <= r;
                    end else if (r_pend) begin
                        r_bq <= r_pq;
                        r_br <= r_pr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_wrap   = (r_scan == CNT_MAX);
    assign w_idx_nx = w_wrap ? r_idx + 2'd1 : r_idx;

    always_comb begin
        w_bcd   = 4'd0;
        w_blank = 1'b0;
        unique case (w_idx_nx)
            2'd3: begin
                w_bcd   = r_dq[7:4];
                w_blank = (r_dq[7:4] == 4'd0);
            end
            2'd2: w_bcd = r_dq[3:0];
            2'd1: begin
                w_bcd   = r_dr[7:4];
                w_blank = (r_dr[7:4] == 4'd0);
            end
            2'd0: w_bcd = r_dr[3:0];
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .i_bcd   (w_bcd),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= 2'd0;
            an     <= 4'b1110;
            seg    <= SEG_DASH;
        end else begin
            r_scan <= w_wrap ? '0 : r_scan + 1'b1;
            r_idx  <= w_idx_nx;
            if (w_wrap) an <= ~(4'b0001 << w_idx_nx);
            seg <= r_valid ? w_seg : SEG_DASH;
        end
    end

endmodule
